// File: rtl/ssd_imagem_port_arbiter.sv
// Shares the single-port image RAM between an Avalon-MM CPU slave and a range-scanning stream reader.
// CPU read data returns 1 cycle after grant; the stream is held off by downstream ready through a 2-entry FIFO.
module ssd_imagem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic              cpu_waitrequest,
  input  logic              strm_start,
  input  logic [ADDR_W-1:0] strm_base,
  input  logic [ADDR_W:0]   strm_count,
  input  logic              strm_abort,
  output logic              strm_busy,
  output logic              strm_done,
  output logic [DATA_W-1:0] strm_data,
  output logic              strm_valid,
  input  logic              strm_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W:0]   remaining;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        fifo_cnt;
  logic              strm_pend;
  logic              cpu_pend;
  logic              prio_cpu;
  logic              zero_done;

  logic              cpu_req;
  logic              strm_req;
  logic              grant_cpu;
  logic              grant_strm;
  logic              pop;
  logic              push;
  logic [2:0]        occ;
  logic              drain_done;

  assign cpu_req = cpu_read | cpu_write;
  assign pop     = (fifo_cnt != 2'd0) & strm_ready;
  assign push    = strm_pend;

  // Occupancy after this cycle's pop, so a draining FIFO still allows back-to-back grants.
  assign occ      = {1'b0, fifo_cnt} - {2'b00, pop} + {2'b00, strm_pend};
  assign strm_req = (state == S_RUN) & (remaining != '0) & (occ < 3'd2) & ~strm_abort;

  assign grant_cpu  = ~reset & cpu_req & (~strm_req | prio_cpu);
  assign grant_strm = ~reset & strm_req & ~grant_cpu;

  assign ram_chipselect = grant_cpu | grant_strm;
  assign ram_write      = grant_cpu & cpu_write;
  assign ram_address    = grant_cpu ? cpu_address : (grant_strm ? scan_addr : '0);
  assign ram_writedata  = grant_cpu ? cpu_writedata : '0;
  assign ram_clken      = 1'b1;

  assign cpu_waitrequest   = reset | (cpu_req & ~grant_cpu);
  assign cpu_readdatavalid = cpu_pend;
  assign cpu_readdata      = cpu_pend ? ram_readdata : '0;

  assign strm_valid = (fifo_cnt != 2'd0);
  assign strm_data  = strm_valid ? fifo_mem[rd_ptr] : '0;
  assign strm_busy  = (state != S_IDLE);

  assign drain_done = (state == S_DRAIN) & pop & (fifo_cnt == 2'd1) & ~strm_pend & ~strm_abort;
  assign strm_done  = zero_done | drain_done;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= ram_readdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      scan_addr <= '0;
      remaining <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
      strm_pend <= 1'b0;
      cpu_pend  <= 1'b0;
      prio_cpu  <= 1'b1;
      zero_done <= 1'b0;
    end else begin
      cpu_pend  <= grant_cpu & ~cpu_write;
      zero_done <= 1'b0;
      if (grant_cpu) begin
        prio_cpu <= 1'b0;
      end else if (grant_strm) begin
        prio_cpu <= 1'b1;
      end

      if (strm_abort) begin
        state     <= S_IDLE;
        rd_ptr    <= 1'b0;
        wr_ptr    <= 1'b0;
        fifo_cnt  <= 2'd0;
        strm_pend <= 1'b0;
      end else begin
        strm_pend <= grant_strm;
        if (push) begin
          wr_ptr <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};

        case (state)
          S_IDLE: begin
            if (strm_start) begin
              if (strm_count == '0) begin
                zero_done <= 1'b1;
              end else begin
                scan_addr <= strm_base;
                remaining <= strm_count;
                state     <= S_RUN;
              end
            end
          end
          S_RUN: begin
            if (grant_strm) begin
              scan_addr <= scan_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
              remaining <= remaining - {{ADDR_W{1'b0}}, 1'b1};
              if (remaining == {{ADDR_W{1'b0}}, 1'b1}) begin
                state <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            if (drain_done) begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ssd_imagem_port_arbiter.sv
// Bench for ssd_imagem_port_arbiter: behavioural RAM, reference memory image and expected-word queues.
module tb_ssd_imagem_port_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] cpu_address = '0;
  logic              cpu_read = 1'b0;
  logic              cpu_write = 1'b0;
  logic [DATA_W-1:0] cpu_writedata = '0;
  logic [DATA_W-1:0] cpu_readdata;
  logic              cpu_readdatavalid;
  logic              cpu_waitrequest;
  logic              strm_start = 1'b0;
  logic [ADDR_W-1:0] strm_base = '0;
  logic [ADDR_W:0]   strm_count = '0;
  logic              strm_abort = 1'b0;
  logic              strm_busy;
  logic              strm_done;
  logic [DATA_W-1:0] strm_data;
  logic              strm_valid;
  logic              strm_ready = 1'b0;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic              ram_clken;
  logic [DATA_W-1:0] ram_readdata = '0;

  ssd_imagem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata),
    .cpu_readdatavalid(cpu_readdatavalid), .cpu_waitrequest(cpu_waitrequest),
    .strm_start(strm_start), .strm_base(strm_base), .strm_count(strm_count),
    .strm_abort(strm_abort), .strm_busy(strm_busy), .strm_done(strm_done),
    .strm_data(strm_data), .strm_valid(strm_valid), .strm_ready(strm_ready),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram     [1 << ADDR_W];
  logic [DATA_W-1:0] ref_mem [1 << ADDR_W];

  always @(posedge clk) begin
    if (ram_chipselect && ram_write) ram[ram_address] <= ram_writedata;
    ram_readdata <= ram[ram_address];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state, advanced at each negedge from the observed handshakes.
  logic [DATA_W-1:0] exp_q [$];
  logic              rd_exp_vld = 1'b0;
  logic [DATA_W-1:0] rd_exp_data = '0;
  logic              zero_pend = 1'b0;
  logic              done_prev = 1'b0;
  logic              cpu_accepted = 1'b0;
  int                wait_run = 0;
  int                words_seen = 0;
  int                done_seen = 0;
  int                cs_seen = 0;
  int                cycle = 0;
  int                first_hs = -1;
  int                last_hs = -1;
  logic              hs;
  logic              exp_done;
  logic [ADDR_W-1:0] scan_a;

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      rd_exp_vld   = 1'b0;
      zero_pend    = 1'b0;
      done_prev    = 1'b0;
      cpu_accepted = 1'b0;
      wait_run     = 0;
    end else begin
      check("cpu_rdv", {31'b0, cpu_readdatavalid}, {31'b0, rd_exp_vld});
      if (rd_exp_vld) check("cpu_rdata", {24'b0, cpu_readdata}, {24'b0, rd_exp_data});
      rd_exp_vld   = 1'b0;
      cpu_accepted = (cpu_read | cpu_write) & ~cpu_waitrequest;
      if (cpu_accepted) begin
        if (cpu_write) ref_mem[cpu_address] = cpu_writedata;
        else begin
          rd_exp_vld  = 1'b1;
          rd_exp_data = ref_mem[cpu_address];
        end
      end
      if (cpu_read | cpu_write) begin
        if (cpu_waitrequest) wait_run++;
        else wait_run = 0;
        check("wait_run", {31'b0, wait_run <= 1}, 32'd1);
      end else wait_run = 0;
      if (ram_chipselect) cs_seen++;

      if (done_prev) check("busy_after_done", {31'b0, strm_busy}, 32'd0);
      hs       = strm_valid & strm_ready;
      exp_done = zero_pend;
      zero_pend = 1'b0;
      if (hs) begin
        if (first_hs < 0) first_hs = cycle;
        last_hs = cycle;
        if (exp_q.size() == 0) check("strm_extra", 32'd1, 32'd0);
        else begin
          check("strm_word", {24'b0, strm_data}, {24'b0, exp_q.pop_front()});
          words_seen++;
          if (exp_q.size() == 0 && !strm_abort) exp_done = 1'b1;
        end
      end
      check("strm_done", {31'b0, strm_done}, {31'b0, exp_done});
      if (strm_done) done_seen++;
      done_prev = strm_done;

      if (strm_abort) exp_q.delete();
      else if (strm_start && !strm_busy) begin
        if (strm_count == '0) zero_pend = 1'b1;
        else for (int i = 0; i < int'(strm_count); i++) begin
          scan_a = strm_base + ADDR_W'(i);
          exp_q.push_back(ref_mem[scan_a]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdata"}, {24'b0, cpu_readdata}, 32'd0);
    check({tag, "_rdv"}, {31'b0, cpu_readdatavalid}, 32'd0);
    check({tag, "_wait"}, {31'b0, cpu_waitrequest}, 32'd1);
    check({tag, "_busy"}, {31'b0, strm_busy}, 32'd0);
    check({tag, "_done"}, {31'b0, strm_done}, 32'd0);
    check({tag, "_sdata"}, {24'b0, strm_data}, 32'd0);
    check({tag, "_svalid"}, {31'b0, strm_valid}, 32'd0);
    check({tag, "_raddr"}, {16'b0, ram_address}, 32'd0);
    check({tag, "_cs"}, {31'b0, ram_chipselect}, 32'd0);
    check({tag, "_we"}, {31'b0, ram_write}, 32'd0);
    check({tag, "_wd"}, {24'b0, ram_writedata}, 32'd0);
    check({tag, "_clken"}, {31'b0, ram_clken}, 32'd1);
  endtask

  task automatic start_scan(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
    strm_base  = b;
    strm_count = c;
    strm_start = 1'b1;
    tick();
    strm_start = 1'b0;
  endtask

  // mode: 0 ready held high, 1 ready toggles 1010..., 2 random ready
  task automatic wait_done(input string tag, input int budget, input int mode, input bit cpu_traffic);
    int d0 = done_seen;
    int n = 0;
    if (cpu_traffic) begin
      cpu_address = ADDR_W'($urandom);
      cpu_read    = 1'b1;
    end
    while (done_seen == d0 && n < budget) begin
      case (mode)
        0:       strm_ready = 1'b1;
        1:       strm_ready = (n % 2) == 0;
        default: strm_ready = 1'($urandom_range(0, 1));
      endcase
      if (cpu_traffic && cpu_accepted) cpu_address = ADDR_W'($urandom);
      n++;
      tick();
    end
    cpu_read = 1'b0;
    check({tag, "_done_cnt"}, done_seen - d0, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int w0;
    int d0;
    int c0;
    int n;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram[i]     = DATA_W'($urandom);
      ref_mem[i] = ram[i];
    end
    for (int i = 0; i < 4; i++) begin
      ram[16'h0010 + i]     = DATA_W'(i + 1);
      ref_mem[16'h0010 + i] = DATA_W'(i + 1);
    end

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst0");
    reset = 1'b0;
    tick();

    // CPU write then read
    cpu_address = 16'h1234; cpu_writedata = 8'hA5; cpu_write = 1'b1;
    #1 check("t1_wr_wait", {31'b0, cpu_waitrequest}, 32'd0);
    tick();
    cpu_write = 1'b0; cpu_read = 1'b1;
    #1 check("t1_rd_wait", {31'b0, cpu_waitrequest}, 32'd0);
    tick();
    cpu_read = 1'b0;
    check("t1_rdv", {31'b0, cpu_readdatavalid}, 32'd1);
    check("t1_rdata", {24'b0, cpu_readdata}, 32'hA5);
    tick();
    check("t1_rdv_off", {31'b0, cpu_readdatavalid}, 32'd0);

    // Stream 1,2,3,4 with ready held high
    first_hs = -1;
    w0 = words_seen;
    start_scan(16'h0010, 17'd4);
    wait_done("t2", 50, 0, 1'b0);
    check("t2_words", words_seen - w0, 32'd4);
    check("t2_consec", last_hs - first_hs, 32'd3);
    tick();

    // Address wrap with toggling ready
    w0 = words_seen;
    start_scan(16'hFFFE, 17'd4);
    wait_done("t3", 60, 1, 1'b0);
    check("t3_words", words_seen - w0, 32'd4);
    tick();

    // CPU read contention during a count-8 scan
    w0 = words_seen;
    start_scan(ADDR_W'($urandom), 17'd8);
    wait_done("t4", 100, 0, 1'b1);
    check("t4_words", words_seen - w0, 32'd8);
    repeat (2) tick();

    // Count 0: done only, no RAM access
    c0 = cs_seen;
    d0 = done_seen;
    start_scan(16'h4000, 17'd0);
    repeat (3) tick();
    check("t5_cs", cs_seen - c0, 32'd0);
    check("t5_done", done_seen - d0, 32'd1);

    // Whole memory from 0
    w0 = words_seen;
    start_scan(16'h0000, 17'h10000);
    wait_done("t6", 70000, 0, 1'b0);
    check("t6_words", words_seen - w0, 32'd65536);
    tick();

    // Abort after 3 of 10 words
    w0 = words_seen;
    strm_ready = 1'b1;
    start_scan(ADDR_W'($urandom), 17'd10);
    n = 0;
    while (words_seen - w0 < 3 && n < 50) begin
      n++;
      tick();
    end
    check("t7_three", {31'b0, words_seen - w0 >= 3}, 32'd1);
    d0 = done_seen;
    strm_abort = 1'b1;
    tick();
    strm_abort = 1'b0;
    check("t7_busy", {31'b0, strm_busy}, 32'd0);
    check("t7_valid", {31'b0, strm_valid}, 32'd0);
    repeat (5) tick();
    check("t7_no_done", done_seen - d0, 32'd0);

    // Random scans with random ready, CPU writes between scans
    for (int k = 0; k < 6; k++) begin
      repeat (3) begin
        cpu_address = ADDR_W'($urandom); cpu_writedata = DATA_W'($urandom); cpu_write = 1'b1;
        tick();
      end
      cpu_write = 1'b0;
      w0 = words_seen;
      c0 = $urandom_range(1, 24);
      start_scan(ADDR_W'($urandom), (ADDR_W+1)'(c0));
      wait_done("t8", 400, 2, 1'($urandom_range(0, 1)));
      check("t8_words", words_seen - w0, c0);
      tick();
    end

    // Reset mid-scan with a CPU read in flight
    strm_ready = 1'b1;
    start_scan(ADDR_W'($urandom), 17'd10);
    repeat (2) tick();
    cpu_address = ADDR_W'($urandom);
    cpu_read = 1'b1;
    tick();
    n = 0;
    while (!cpu_accepted && n < 5) begin
      n++;
      tick();
    end
    check("t9_rd_acc", {31'b0, cpu_accepted}, 32'd1);
    reset = 1'b1;
    cpu_read = 1'b0;
    #1;
    check_reset_vals("t9a");
    tick();
    check_reset_vals("t9b");
    reset = 1'b0;
    repeat (4) tick();
    check("t9_busy", {31'b0, strm_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
